board_io_conditioner: RTL and testbench
=======================================

BOARD_IO_CONDITIONER -- requirements
Module: board_io_conditioner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning board-clock cycles per pixel period; legal range >=2.
REQ-002 SHALL have parameter NKEYS, default 4, meaning number of board key inputs.
REQ-003 SHALL have parameter DB_CYCLES, default 16, meaning consecutive stable clk cycles needed to accept a key change; legal range >=1.
REQ-004 SHALL have parameter RGB_W, default 3, meaning colour bus width.
REQ-005 SHALL have parameter SYNC_IDLE, default 1'b0, meaning reset level of the hsync and vsync outputs.
REQ-006 SHALL have port clk, input, 1 bit: board clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port keys_in, input, NKEYS bits: raw asynchronous key levels, 1 = pressed.
REQ-009 SHALL have ports hsync_in, vsync_in (input, 1 bit each) and rgb_in (input, RGB_W bits): video from the game core, valid in the pix_ce domain.
REQ-010 SHALL have port pix_clk, output, 1 bit: divided clock for the game core.
REQ-011 SHALL have port pix_ce, output, 1 bit: one-clk-wide enable, once per pixel period.
REQ-012 SHALL have port keys_db, output, NKEYS bits: debounced key levels.
REQ-013 SHALL have ports key_press and key_release, output, NKEYS bits each: one-clk pulses on a debounced rise or fall.
REQ-014 SHALL have ports hsync, vsync (output, 1 bit each) and rgb (output, RGB_W bits): registered video to the board pins.

Function
REQ-015 SHALL hold a divider counter cnt that steps 0..CLK_DIV-1 and then wraps to 0, advancing every clk cycle.
REQ-016 SHALL drive pix_ce high exactly when cnt == CLK_DIV-1.
REQ-017 SHALL drive pix_clk from a flop loaded with (cnt_next >= CLK_DIV/2), using integer division, so that pix_clk is glitch-free; for CLK_DIV=2 it toggles every clk cycle.
REQ-018 SHALL pass each keys_in bit through a two-flop synchroniser before any further use.
REQ-019 SHALL keep a per-key counter of width clog2(DB_CYCLES)+1, behaving as follows:
- synchronised bit equal to keys_db: counter clears;
- otherwise the counter increments;
- on the cycle the counter equals DB_CYCLES-1 while still differing: keys_db flips and the counter clears.
REQ-020 SHALL make a held key change visible on keys_db exactly 2+DB_CYCLES clk edges after the first edge at which it is sampled.
REQ-021 SHALL reset the debounce counter on any bounce shorter than DB_CYCLES cycles, leaving keys_db unchanged.
REQ-022 SHALL register key_press/key_release on the same edge keys_db changes: press on 0->1, release on 1->0, each exactly one clk wide; keys are independent and may pulse simultaneously.
REQ-023 SHALL load hsync, vsync and rgb from hsync_in, vsync_in and rgb_in only on edges where pix_ce is high, and hold them otherwise; latency is one pixel period.
REQ-024 SHALL reject CLK_DIV<2 or DB_CYCLES<1 at elaboration.

Reset
REQ-025 SHALL, on reset assertion, immediately clear:
- cnt, pix_clk, pix_ce, keys_db, key_press, key_release, synchroniser flops and debounce counters to 0;
- rgb to 0;
- hsync and vsync to SYNC_IDLE.
REQ-026 SHALL abort any debounce in progress if reset arrives mid-operation; a key held through reset yields key_press 2+DB_CYCLES edges after reset deasserts.

Structure
REQ-027 SHALL place the default values of CLK_DIV, DB_CYCLES and RGB_W in the shared package board_io_pkg, alongside the clog2 helper.
REQ-028 SHALL instantiate one sub-module, key_debounce (synchroniser, counter, level and edge pulses for a single key), once per key in a generate loop.

Verification
REQ-029 SHALL cover divider: CLK_DIV=3 after reset -> pix_ce high on clk edges 3, 6, 9; pix_clk pattern 0,1,1 repeating; CLK_DIV=2 -> pix_clk toggles every cycle.
REQ-030 SHALL cover clean press: DB_CYCLES=4, keys_in[0] 0->1 held -> keys_db[0] rises and key_press[0] pulses one cycle at edge 6; other bits stay quiet.
REQ-031 SHALL cover bounce: keys_in[1] high for 3 cycles, low, high again held, with DB_CYCLES=4 -> no change after the first 3 cycles; keys_db[1] rises 6 edges after the second rise.
REQ-032 SHALL cover release and simultaneous keys: keys 2 and 3 change in the same cycle -> key_release[2] and key_press[3] pulse on the same edge.
REQ-033 SHALL cover video stage: rgb_in=3'b101 presented in a pixel period -> rgb=3'b101 after the next pix_ce edge and held until the following pix_ce edge.
REQ-034 SHALL cover reset mid-debounce: reset pulse at debounce count 2 -> all outputs at reset values, hsync=vsync=SYNC_IDLE, counting restarts from 0.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared defaults and helpers for the board I/O conditioning block.
package board_io_pkg;

  localparam int unsigned CLK_DIV_DEFAULT   = 2;
  localparam int unsigned DB_CYCLES_DEFAULT = 16;
  localparam int unsigned RGB_W_DEFAULT     = 3;

  // Number of bits needed to index 'value' distinct states (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/board_io_conditioner_key_debounce.sv
// Single-key conditioner: two-flop synchroniser, stability counter,
// debounced level and one-cycle press/release pulses.
module key_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W    = clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             flip;

  // Two-flop synchroniser for the asynchronous key input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles the synchronised key disagrees with the level
  always_comb begin
    flip     = 1'b0;
    cnt_next = '0;
    if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        flip = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Debounced level, stability counter and edge pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      level <= level ^ flip;
      rise  <= flip & ~level;
      fall  <= flip & level;
    end
  end

endmodule

// File: rtl/board_io_conditioner.sv
// Board-side conditioning: pixel clock/enable divider, key debouncing with
// edge pulses, and a pixel-rate output register for the video pins.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int unsigned NKEYS     = 4,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned RGB_W     = RGB_W_DEFAULT,
  parameter logic        SYNC_IDLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_clk,
  output logic             pix_ce,
  output logic [NKEYS-1:0] keys_db,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("DB_CYCLES must be at least 1");
  end

  localparam int unsigned      CNT_W    = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Divider next count: 0..CLK_DIV-1 then wrap
  always_comb begin
    cnt_next = cnt + 1'b1;
    if (cnt == CNT_LAST) cnt_next = '0;
  end

  // Divider state; pix_clk/pix_ce come from flops so they are glitch-free,
  // and pix_ce is loaded from cnt_next so it is high while cnt == CLK_DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pix_clk <= 1'b0;
      pix_ce  <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      pix_clk <= (cnt_next >= CNT_HALF);
      pix_ce  <= (cnt_next == CNT_LAST);
    end
  end

  // Video pin register, updated once per pixel period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
      rgb   <= '0;
    end else if (pix_ce) begin
      hsync <= hsync_in;
      vsync <= vsync_in;
      rgb   <= rgb_in;
    end
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
      .clk     (clk),
      .reset   (reset),
      .key_raw (keys_in[k]),
      .level   (keys_db[k]),
      .rise    (key_press[k]),
      .fall    (key_release[k])
    );
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Self-checking bench for board_io_conditioner: directed scenarios plus a
// randomized run against a sliding-window reference model.
module tb_board_io_conditioner;

  localparam int NK = 4;
  localparam int RW = 3;
  localparam int D1 = 3;
  localparam int D2 = 2;
  localparam int DB = 4;

  logic          clk;
  logic          reset;
  logic [NK-1:0] keys_in;
  logic          hsync_in;
  logic          vsync_in;
  logic [RW-1:0] rgb_in;

  logic          pix_clk, pix_ce, hsync, vsync;
  logic [NK-1:0] keys_db, key_press, key_release;
  logic [RW-1:0] rgb;

  logic          pix_clk2, pix_ce2, hsync2, vsync2;
  logic [NK-1:0] keys_db2, key_press2, key_release2;
  logic [RW-1:0] rgb2;

  int n_cmp;
  int n_fail;

  // Reference model state
  int            m_e;
  logic [NK-1:0] m_db, m_press, m_rel, m_flip;
  logic [RW-1:0] m_rgb, m_rgb2;
  logic          m_hs, m_vs, m_hs2, m_vs2;
  logic [NK-1:0] hist[$];

  board_io_conditioner #(
    .CLK_DIV   (D1),
    .NKEYS     (NK),
    .DB_CYCLES (DB),
    .RGB_W     (RW),
    .SYNC_IDLE (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys_in     (keys_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .rgb_in      (rgb_in),
    .pix_clk     (pix_clk),
    .pix_ce      (pix_ce),
    .keys_db     (keys_db),
    .key_press   (key_press),
    .key_release (key_release),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb)
  );

  board_io_conditioner #(
    .CLK_DIV   (D2),
    .NKEYS     (NK),
    .DB_CYCLES (DB),
    .RGB_W     (RW),
    .SYNC_IDLE (1'b1)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .keys_in     (keys_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .rgb_in      (rgb_in),
    .pix_clk     (pix_clk2),
    .pix_ce      (pix_ce2),
    .keys_db     (keys_db2),
    .key_press   (key_press2),
    .key_release (key_release2),
    .hsync       (hsync2),
    .vsync       (vsync2),
    .rgb         (rgb2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // One clock edge: advance the model, then step 1 time unit past the edge.
  // Model rule: a debounced bit flips when the last DB synchronised samples
  // (raw keys seen 2..DB+1 edges ago) all differ from the current level.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_e = 0;
      m_db = '0; m_press = '0; m_rel = '0;
      m_rgb = '0; m_hs = 1'b0; m_vs = 1'b0;
      m_rgb2 = '0; m_hs2 = 1'b1; m_vs2 = 1'b1;
      hist.delete();
      for (int i = 0; i < DB + 1; i++) hist.push_back('0);
    end else begin
      m_e++;
      for (int k = 0; k < NK; k++) begin
        m_flip[k] = 1'b1;
        for (int j = 2; j <= DB + 1; j++) begin
          if (hist[hist.size() - j][k] == m_db[k]) m_flip[k] = 1'b0;
        end
      end
      m_press = m_flip & ~m_db;
      m_rel   = m_flip & m_db;
      m_db    = m_db ^ m_flip;
      hist.push_back(keys_in);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      if (m_e % D1 == 0) begin
        m_rgb = rgb_in; m_hs = hsync_in; m_vs = vsync_in;
      end
      if (m_e % D2 == 0) begin
        m_rgb2 = rgb_in; m_hs2 = hsync_in; m_vs2 = vsync_in;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); rgb_in = 3'($urandom) | 3'b001;
      tick();
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (pix_clk !== 1'b0) begin n_fail++; $display("FAIL rst_pix_clk: got %b want 0", pix_clk); end
    n_cmp++; if (pix_ce !== 1'b0) begin n_fail++; $display("FAIL rst_pix_ce: got %b want 0", pix_ce); end
    n_cmp++; if (keys_db !== '0) begin n_fail++; $display("FAIL rst_keys_db: got %b want 0", keys_db); end
    n_cmp++; if (key_press !== '0) begin n_fail++; $display("FAIL rst_press: got %b want 0", key_press); end
    n_cmp++; if (key_release !== '0) begin n_fail++; $display("FAIL rst_release: got %b want 0", key_release); end
    n_cmp++; if (rgb !== '0) begin n_fail++; $display("FAIL rst_rgb: got %b want 0", rgb); end
    n_cmp++; if ({hsync, vsync} !== 2'b00) begin
      n_fail++; $display("FAIL rst_sync: got %b%b want 00", hsync, vsync);
    end
    n_cmp++; if ({hsync2, vsync2} !== 2'b11) begin
      n_fail++; $display("FAIL rst_sync_idle1: got %b%b want 11", hsync2, vsync2);
    end
    n_cmp++; if ({pix_clk2, pix_ce2, rgb2} !== '0) begin
      n_fail++; $display("FAIL rst_dut2_div_rgb: got %b%b%b want 0", pix_clk2, pix_ce2, rgb2);
    end
    keys_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_divider();
    logic exp_ce, exp_clk;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_ce  = (i % D1 == D1 - 1);
      exp_clk = ((i % D1) >= D1 / 2);
      n_cmp++; if (pix_ce !== exp_ce) begin
        n_fail++; $display("FAIL div3_pix_ce after edge %0d: got %b want %b", i, pix_ce, exp_ce);
      end
      n_cmp++; if (pix_clk !== exp_clk) begin
        n_fail++; $display("FAIL div3_pix_clk after edge %0d: got %b want %b", i, pix_clk, exp_clk);
      end
      n_cmp++; if (pix_clk2 !== 1'(i % 2)) begin
        n_fail++; $display("FAIL div2_pix_clk after edge %0d: got %b want %b", i, pix_clk2, 1'(i % 2));
      end
      n_cmp++; if (pix_ce2 !== 1'(i % 2)) begin
        n_fail++; $display("FAIL div2_pix_ce after edge %0d: got %b want %b", i, pix_ce2, 1'(i % 2));
      end
    end
  endtask

  task automatic test_clean_press();
    logic [NK-1:0] exp_db, exp_pr;
    do_reset();
    keys_in = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_db = (i >= 6) ? 4'b0001 : 4'b0000;
      exp_pr = (i == 6) ? 4'b0001 : 4'b0000;
      n_cmp++; if ({keys_db, key_press, key_release} !== {exp_db, exp_pr, 4'b0000}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got db=%b pr=%b rl=%b want db=%b pr=%b rl=0000",
                 i, keys_db, key_press, key_release, exp_db, exp_pr);
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_db, exp_pr;
    keys_in[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) keys_in[1] = 1'b0;
      if (i == 4) keys_in[1] = 1'b1;
      // second rise is first sampled on edge 5, so it lands on edge 5+5
      exp_db = (i >= 10);
      exp_pr = (i == 10);
      n_cmp++; if ({keys_db[1], key_press[1], keys_db[0]} !== {exp_db, exp_pr, 1'b1}) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got db1=%b pr1=%b db0=%b want db1=%b pr1=%b db0=1",
                 i, keys_db[1], key_press[1], keys_db[0], exp_db, exp_pr);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] exp_db, exp_pr, exp_rl;
    keys_in = 4'b0111;
    repeat (8) tick();
    keys_in = 4'b1011;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_db = (i >= 6) ? 4'b1011 : 4'b0111;
      exp_pr = (i == 6) ? 4'b1000 : 4'b0000;
      exp_rl = (i == 6) ? 4'b0100 : 4'b0000;
      n_cmp++; if ({keys_db, key_press, key_release} !== {exp_db, exp_pr, exp_rl}) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: got db=%b pr=%b rl=%b want db=%b pr=%b rl=%b",
                 i, keys_db, key_press, key_release, exp_db, exp_pr, exp_rl);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NK-1:0] exp_db, exp_pr;
    keys_in = 4'b1111;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    n_cmp++; if ({keys_db, key_press, key_release} !== '0) begin
      n_fail++; $display("FAIL rst_mid_keys: got db=%b pr=%b rl=%b want all 0",
                         keys_db, key_press, key_release);
    end
    n_cmp++; if ({pix_clk, pix_ce, hsync, vsync, rgb} !== '0) begin
      n_fail++; $display("FAIL rst_mid_video: got clk=%b ce=%b hs=%b vs=%b rgb=%b want all 0",
                         pix_clk, pix_ce, hsync, vsync, rgb);
    end
    n_cmp++; if ({hsync2, vsync2} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_sync_idle1: got %b%b want 11", hsync2, vsync2);
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_db = (i >= 6) ? 4'b1111 : 4'b0000;
      exp_pr = (i == 6) ? 4'b1111 : 4'b0000;
      n_cmp++; if ({keys_db, key_press, key_release} !== {exp_db, exp_pr, 4'b0000}) begin
        n_fail++;
        $display("FAIL rst_mid_restart edge %0d: got db=%b pr=%b rl=%b want db=%b pr=%b",
                 i, keys_db, key_press, key_release, exp_db, exp_pr);
      end
      n_cmp++; if (pix_ce !== 1'(i % D1 == D1 - 1)) begin
        n_fail++; $display("FAIL rst_mid_pix_ce edge %0d: got %b", i, pix_ce);
      end
    end
  endtask

  task automatic test_video();
    rgb_in = 3'b000; hsync_in = 1'b0;
    for (int g = 0; g < D1 && (m_e % D1) != 1; g++) tick();
    rgb_in = 3'b101; hsync_in = 1'b1;
    tick();
    n_cmp++; if (rgb !== 3'b000) begin
      n_fail++; $display("FAIL video_early: got %b want 000", rgb);
    end
    tick();
    n_cmp++; if ({hsync, rgb} !== 4'b1101) begin
      n_fail++; $display("FAIL video_load: got hs=%b rgb=%b want hs=1 rgb=101", hsync, rgb);
    end
    rgb_in = 3'b010; hsync_in = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++; if ({hsync, rgb} !== 4'b1101) begin
        n_fail++; $display("FAIL video_hold %0d: got hs=%b rgb=%b want hs=1 rgb=101", i, hsync, rgb);
      end
    end
    tick();
    n_cmp++; if ({hsync, rgb} !== 4'b0010) begin
      n_fail++; $display("FAIL video_next: got hs=%b rgb=%b want hs=0 rgb=010", hsync, rgb);
    end
  endtask

  task automatic test_random();
    int kk;
    logic exp_ce, exp_clk;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        kk = $urandom_range(0, NK - 1);
        keys_in[kk] = ~keys_in[kk];
      end
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); rgb_in = 3'($urandom);
      tick();
      exp_ce  = (m_e % D1 == D1 - 1);
      exp_clk = ((m_e % D1) >= D1 / 2);
      n_cmp++; if ({keys_db, key_press, key_release} !== {m_db, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL rand_keys edge %0d: got db=%b pr=%b rl=%b want db=%b pr=%b rl=%b",
                 m_e, keys_db, key_press, key_release, m_db, m_press, m_rel);
      end
      n_cmp++; if ({keys_db2, key_press2, key_release2} !== {m_db, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL rand_keys2 edge %0d: got db=%b pr=%b rl=%b want db=%b pr=%b rl=%b",
                 m_e, keys_db2, key_press2, key_release2, m_db, m_press, m_rel);
      end
      n_cmp++; if ({pix_ce, pix_clk} !== {exp_ce, exp_clk}) begin
        n_fail++; $display("FAIL rand_div edge %0d: got ce=%b clk=%b want ce=%b clk=%b",
                           m_e, pix_ce, pix_clk, exp_ce, exp_clk);
      end
      n_cmp++; if ({hsync, vsync, rgb} !== {m_hs, m_vs, m_rgb}) begin
        n_fail++; $display("FAIL rand_video edge %0d: got %b%b %b want %b%b %b",
                           m_e, hsync, vsync, rgb, m_hs, m_vs, m_rgb);
      end
      n_cmp++; if ({hsync2, vsync2, rgb2} !== {m_hs2, m_vs2, m_rgb2}) begin
        n_fail++; $display("FAIL rand_video2 edge %0d: got %b%b %b want %b%b %b",
                           m_e, hsync2, vsync2, rgb2, m_hs2, m_vs2, m_rgb2);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    keys_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = '0;
    repeat (2) tick();
    test_reset();
    test_divider();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_video();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
